// File: rtl/billiard_pkg.sv
`timescale 1ns/1ps
// Shared types, widths and the 16-step aim direction table for the billiard game.
package billiard_pkg;

    localparam int unsigned VEL_W    = 11;
    localparam int unsigned POWER_W  = 5;
    localparam int unsigned ANGLE_W  = 4;
    localparam int unsigned DIR_W    = 6;
    localparam int unsigned NUM_DIRS = 16;
    localparam int unsigned PROD_W   = 12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHARGING = 2'd1,
        FIRE     = 2'd2,
        ROLLING  = 2'd3
    } shot_state_t;

    // round(16*cos(22.5k deg)), k = 0..15
    localparam logic signed [DIR_W-1:0] DIR_X [NUM_DIRS] = '{
        6'sd16,  6'sd15,  6'sd11,  6'sd6,   6'sd0,  -6'sd6,  -6'sd11, -6'sd15,
        -6'sd16, -6'sd15, -6'sd11, -6'sd6,  6'sd0,   6'sd6,   6'sd11,  6'sd15
    };

    // round(16*sin(22.5k deg)), k = 0..15 (+Y is screen down)
    localparam logic signed [DIR_W-1:0] DIR_Y [NUM_DIRS] = '{
        6'sd0,   6'sd6,   6'sd11,  6'sd15,  6'sd16,  6'sd15,  6'sd11,  6'sd6,
        6'sd0,  -6'sd6,  -6'sd11, -6'sd15, -6'sd16, -6'sd15, -6'sd11, -6'sd6
    };

    // dir*power*scale, evaluated signed at 12 bits; the result always fits VEL_W
    function automatic logic signed [VEL_W-1:0] shot_velocity(
        input logic signed [DIR_W-1:0]  dir,
        input logic [POWER_W-1:0]       pwr,
        input int unsigned              scale
    );
        logic signed [PROD_W-1:0] d_ext;
        logic signed [PROD_W-1:0] p_ext;
        logic signed [PROD_W-1:0] s_ext;
        logic signed [PROD_W-1:0] prod;
        d_ext = {{(PROD_W-DIR_W){dir[DIR_W-1]}}, dir};
        p_ext = {{(PROD_W-POWER_W){1'b0}}, pwr};
        s_ext = PROD_W'(scale);
        prod  = d_ext * p_ext * s_ext;
        return VEL_W'(prod);
    endfunction

endpackage

// File: rtl/frame_hold_counter.sv
`timescale 1ns/1ps
// Counts frames a condition is held and ticks once every HOLD_FRAMES frames.
module frame_hold_counter #(
    parameter int unsigned HOLD_FRAMES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic tick_c
);

    localparam int unsigned CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick_c = advance && !clear && (cnt == CNT_W'(HOLD_FRAMES - 1));

    // frame counter: cleared on request or on wrap, bumped on each counted frame
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || tick_c) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cue_shot_ctrl.sv
`timescale 1ns/1ps
// Cue shot controller: aim, charge, fire one velocity write, then wait for the ball to stop.
import billiard_pkg::*;

module cue_shot_ctrl #(
    parameter int unsigned AIM_REPEAT    = 8,
    parameter int unsigned CHARGE_FRAMES = 4,
    parameter int unsigned MAX_POWER     = 31,
    parameter int unsigned VEL_SCALE     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     startOfFrame,
    input  logic                     aimLeftKey,
    input  logic                     aimRightKey,
    input  logic                     chargeKey,
    input  logic                     ballStopped,
    output logic                     velocityWriteEnable,
    output logic signed [VEL_W-1:0]  shotVelocityX,
    output logic signed [VEL_W-1:0]  shotVelocityY,
    output logic [ANGLE_W-1:0]       angleIdx,
    output logic [POWER_W-1:0]       power,
    output logic                     shotActive
);

    shot_state_t state;
    shot_state_t next_state;

    logic       aim_one_key;
    logic       aim_tick_c;
    logic       charge_tick_c;
    logic       enter_fire_c;
    logic       enter_charge_c;
    logic       seen_drop;
    logic [1:0] roll_frames;

    assign aim_one_key = aimLeftKey ^ aimRightKey;

    frame_hold_counter #(.HOLD_FRAMES(AIM_REPEAT)) u_aim_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state != IDLE) || !aim_one_key),
        .advance (startOfFrame && (state == IDLE) && aim_one_key),
        .tick_c  (aim_tick_c)
    );

    frame_hold_counter #(.HOLD_FRAMES(CHARGE_FRAMES)) u_charge_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != CHARGING),
        .advance (startOfFrame && (state == CHARGING) && chargeKey),
        .tick_c  (charge_tick_c)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state decode; ROLLING gives up after two frames if the ball never moved
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (chargeKey && ballStopped) next_state = CHARGING;
            end
            CHARGING: begin
                if (!chargeKey) next_state = (power == '0) ? IDLE : FIRE;
            end
            FIRE: begin
                next_state = ROLLING;
            end
            ROLLING: begin
                if (seen_drop && ballStopped) begin
                    next_state = IDLE;
                end else if (!seen_drop && ballStopped && startOfFrame && (roll_frames == 2'd1)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // state-derived outputs and transition strobes
    always_comb begin
        shotActive     = 1'b0;
        enter_fire_c   = 1'b0;
        enter_charge_c = 1'b0;
        if ((state == FIRE) || (state == ROLLING)) shotActive = 1'b1;
        if ((state == CHARGING) && (next_state == FIRE)) enter_fire_c = 1'b1;
        if ((state == IDLE) && (next_state == CHARGING)) enter_charge_c = 1'b1;
    end

    // aim, power, shot velocity and roll-tracking registers
    always_ff @(posedge clk) begin
        if (reset) begin
            angleIdx            <= '0;
            power               <= '0;
            velocityWriteEnable <= 1'b0;
            shotVelocityX       <= '0;
            shotVelocityY       <= '0;
            seen_drop           <= 1'b0;
            roll_frames         <= '0;
        end else begin
            velocityWriteEnable <= enter_fire_c;

            if (enter_fire_c) begin
                shotVelocityX <= shot_velocity(DIR_X[angleIdx], power, VEL_SCALE);
                shotVelocityY <= shot_velocity(DIR_Y[angleIdx], power, VEL_SCALE);
            end

            if ((state == IDLE) && aim_tick_c) begin
                angleIdx <= aimRightKey ? angleIdx + ANGLE_W'(1) : angleIdx - ANGLE_W'(1);
            end

            if (enter_charge_c || (state == FIRE)) begin
                power <= '0;
            end else if ((state == CHARGING) && charge_tick_c && (power < POWER_W'(MAX_POWER))) begin
                power <= power + POWER_W'(1);
            end

            if (state != ROLLING) begin
                seen_drop   <= 1'b0;
                roll_frames <= '0;
            end else begin
                if (!ballStopped) seen_drop <= 1'b1;
                if (startOfFrame && (roll_frames != 2'd3)) roll_frames <= roll_frames + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_cue_shot_ctrl.sv
`timescale 1ns/1ps
// Bench for cue_shot_ctrl: directed table, hand sequences and randomized shots against a shot-level model.
module tb_cue_shot_ctrl;

    logic               clk = 1'b0;
    logic               reset;
    logic               startOfFrame;
    logic               aimLeftKey;
    logic               aimRightKey;
    logic               chargeKey;
    logic               ballStopped;
    logic               velocityWriteEnable;
    logic signed [10:0] shotVelocityX;
    logic signed [10:0] shotVelocityY;
    logic [3:0]         angleIdx;
    logic [4:0]         power;
    logic               shotActive;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int exp_pulses = 0;
    int m_angle = 0;
    int dir_x [16] = '{16, 15, 11, 6, 0, -6, -11, -15, -16, -15, -11, -6, 0, 6, 11, 15};

    typedef struct {
        int keys;       // bit0 right, bit1 left
        int aim_n;
        int chg_n;
        int exp_angle;
        int exp_power;
        int exp_vx;
        int exp_vy;
        int drop;       // frames of ballStopped=0 after the shot, 0 = never moves
    } vec_t;

    vec_t vecs [7];

    cue_shot_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .startOfFrame        (startOfFrame),
        .aimLeftKey          (aimLeftKey),
        .aimRightKey         (aimRightKey),
        .chargeKey           (chargeKey),
        .ballStopped         (ballStopped),
        .velocityWriteEnable (velocityWriteEnable),
        .shotVelocityX       (shotVelocityX),
        .shotVelocityY       (shotVelocityY),
        .angleIdx            (angleIdx),
        .power               (power),
        .shotActive          (shotActive)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (velocityWriteEnable === 1'b1) pulses++;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
            tick();
            tick();
        end
    endtask

    task automatic aim(input int keys, input int n, input int exp_angle);
        aimRightKey = keys[0];
        aimLeftKey  = keys[1];
        frames(n);
        aimRightKey = 1'b0;
        aimLeftKey  = 1'b0;
        tick();
        check("angle", int'(angleIdx), exp_angle);
        m_angle = exp_angle;
    endtask

    task automatic charge(input int n, input int ep, input int evx, input int evy, input bit noisy);
        chargeKey = 1'b1;
        tick();
        check("charge_not_active", int'(shotActive), 0);
        if (noisy) begin
            aimRightKey = 1'($urandom_range(0, 1));
            aimLeftKey  = 1'($urandom_range(0, 1));
        end
        frames(n);
        check("power", int'(power), ep);
        chargeKey   = 1'b0;
        aimRightKey = 1'b0;
        aimLeftKey  = 1'b0;
        tick();
        if (ep == 0) begin
            check("abort_no_we", int'(velocityWriteEnable), 0);
            tick();
            check("abort_idle", int'(shotActive), 0);
        end else begin
            exp_pulses++;
            check("fire_we", int'(velocityWriteEnable), 1);
            check("fire_vx", int'(shotVelocityX), evx);
            check("fire_vy", int'(shotVelocityY), evy);
            check("fire_active", int'(shotActive), 1);
            tick();
            check("we_one_cycle", int'(velocityWriteEnable), 0);
            check("power_cleared", int'(power), 0);
            check("roll_active", int'(shotActive), 1);
            check("vx_held", int'(shotVelocityX), evx);
        end
        check("angle_kept", int'(angleIdx), m_angle);
    endtask

    task automatic roll(input int drop);
        if (drop > 0) begin
            ballStopped = 1'b0;
            frames(drop);
            check("rolling_active", int'(shotActive), 1);
            ballStopped = 1'b1;
            check("rise_still_active", int'(shotActive), 1);
            tick();
            check("stop_idle", int'(shotActive), 0);
        end else begin
            frames(1);
            check("stuck_active_f1", int'(shotActive), 1);
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            check("stuck_idle_f2", int'(shotActive), 0);
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{1, 24, 0, 3, 0, 0, 0, 0};
        vecs[1] = '{2, 32, 0, 15, 0, 0, 0, 0};
        vecs[2] = '{3, 16, 0, 15, 0, 0, 0, 0};
        vecs[3] = '{1, 8, 20, 0, 5, 160, 0, 50};
        vecs[4] = '{1, 80, 200, 10, 31, -682, -682, 0};
        vecs[5] = '{0, 0, 3, 10, 0, 0, 0, 0};
        vecs[6] = '{2, 40, 13, 5, 3, -36, 90, 2};

        reset = 1'b1;
        startOfFrame = 1'b0;
        aimLeftKey = 1'b0;
        aimRightKey = 1'b0;
        chargeKey = 1'b0;
        ballStopped = 1'b1;
        tick();
        tick();
        tick();
        check("rst_angle", int'(angleIdx), 0);
        check("rst_power", int'(power), 0);
        check("rst_we", int'(velocityWriteEnable), 0);
        check("rst_vx", int'(shotVelocityX), 0);
        check("rst_vy", int'(shotVelocityY), 0);
        check("rst_active", int'(shotActive), 0);
        reset = 1'b0;
        tick();

        // reset in the middle of a charge aborts without a pulse
        aim(1, 16, 2);
        chargeKey = 1'b1;
        tick();
        frames(28);
        check("midchg_power", int'(power), 7);
        reset = 1'b1;
        chargeKey = 1'b0;
        tick();
        check("midrst_power", int'(power), 0);
        check("midrst_angle", int'(angleIdx), 0);
        check("midrst_active", int'(shotActive), 0);
        check("midrst_we", int'(velocityWriteEnable), 0);
        reset = 1'b0;
        m_angle = 0;
        tick();
        check("midrst_idle", int'(shotActive), 0);
        check("midrst_pulses", pulses, exp_pulses);

        // directed table
        for (int i = 0; i < 7; i++) begin
            aim(vecs[i].keys, vecs[i].aim_n, vecs[i].exp_angle);
            if (vecs[i].chg_n > 0) begin
                charge(vecs[i].chg_n, vecs[i].exp_power, vecs[i].exp_vx, vecs[i].exp_vy, 1'b0);
                if (vecs[i].exp_power > 0) roll(vecs[i].drop);
            end
            check("tbl_pulses", pulses, exp_pulses);
        end

        // charge while the ball is still moving is ignored
        ballStopped = 1'b0;
        chargeKey = 1'b1;
        frames(3);
        check("moving_no_charge", int'(shotActive), 0);
        check("moving_power", int'(power), 0);
        chargeKey = 1'b0;
        tick();
        ballStopped = 1'b1;
        tick();
        check("moving_pulses", pulses, exp_pulses);

        // randomized shots against the shot-level model
        for (int r = 0; r < 15; r++) begin
            int keys, an, steps, cn, p, drop;
            keys = int'($urandom_range(0, 3));
            an   = int'($urandom_range(0, 40));
            steps = an / 8;
            if (keys == 1) m_angle = (m_angle + steps) % 16;
            else if (keys == 2) m_angle = (m_angle + 16 - (steps % 16)) % 16;
            aim(keys, an, m_angle);
            cn = int'($urandom_range(0, 150));
            p  = (cn / 4 > 31) ? 31 : cn / 4;
            charge(cn, p, dir_x[m_angle] * p * 2, dir_x[(m_angle + 12) % 16] * p * 2, 1'b1);
            if (p > 0) begin
                drop = int'($urandom_range(0, 4));
                roll(drop);
            end
            check("rnd_pulses", pulses, exp_pulses);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
